// File: rtl/alu_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package alu_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/cla8_cin.sv
// Combinational 8-bit carry-lookahead adder with carry-in.
module cla8_cin
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;
  logic               w_term;
  logic               w_pp;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flattened sum of products over all lower generate terms and cin.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    w_term = 1'b0;
    w_pp   = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      w_term = w_g[i];
      w_pp   = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term = w_term | (w_pp & w_g[j]);
        w_pp   = w_pp & w_p[j];
      end
      w_term     = w_term | (w_pp & cin);
      w_c[i + 1] = w_term;
    end
  end

  assign s    = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial signed add/subtract: one 8-bit CLA slice per cycle, LSB first, with a
// registered carry; results and flags are loaded together when the last slice completes.
module addsub_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = $clog2(NSLICE);

  seq_state_t r_state;
  seq_state_t w_state_d;

  logic [NSLICE-1:0][SLICE_W-1:0] r_a;
  logic [NSLICE-1:0][SLICE_W-1:0] r_b;
  logic [NSLICE-1:0][SLICE_W-1:0] r_work;
  logic [NSLICE-1:0][SLICE_W-1:0] w_work_d;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_carry;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovfl;
  logic             r_zero;

  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;
  logic               w_last;
  logic               w_ovfl;

  cla8_cin u_cla (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_last = (r_idx == IDX_W'(NSLICE - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_d = RUN;
      RUN:     if (w_last) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    w_sa            = r_a[r_idx];
    w_sb            = r_b[r_idx];
    // On the last slice this is the complete result.
    w_work_d        = r_work;
    w_work_d[r_idx] = w_s;
  end

  // Operands already carry the inverted b, so this is the plain same-sign overflow test.
  assign w_ovfl = (r_a[NSLICE-1][SLICE_W-1] == r_b[NSLICE-1][SLICE_W-1]) &&
                  (w_work_d[NSLICE-1][SLICE_W-1] != r_a[NSLICE-1][SLICE_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovfl  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= mode ? ~b : b;
            r_carry <= mode;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_work  <= w_work_d;
          r_carry <= w_co;
          if (w_last) begin
            r_sum  <= w_work_d;
            r_cout <= w_co;
            r_zero <= (w_work_d == '0);
            r_ovfl <= w_ovfl;
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovfl = r_ovfl;
  assign zero = r_zero;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench: directed corner cases on a 16-bit instance, random back-to-back
// traffic on a 32-bit instance, both against an arithmetic reference model.
module tb_addsub_seq_ctrl;

  logic        clk;
  logic        rst;

  logic        start16, mode16, busy16, done16, cout16, ovfl16, zero16;
  logic [15:0] a16, b16, sum16;

  logic        start32, mode32, busy32, done32, cout32, ovfl32, zero32;
  logic [31:0] a32, b32, sum32;

  int errors;
  int checks;

  addsub_seq_ctrl #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .mode  (mode16),
    .a     (a16),
    .b     (b16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16),
    .ovfl  (ovfl16),
    .zero  (zero16)
  );

  addsub_seq_ctrl #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start32),
    .mode  (mode32),
    .a     (a32),
    .b     (b32),
    .busy  (busy32),
    .done  (done32),
    .sum   (sum32),
    .cout  (cout32),
    .ovfl  (ovfl32),
    .zero  (zero32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on w-bit values.
  task automatic model(input int w, input bit m, input longint unsigned aa,
                       input longint unsigned bb, output longint unsigned s,
                       output bit co, output bit ov, output bit z);
    longint unsigned mask;
    longint sa, sb, t, lim;
    mask = (64'd1 << w) - 64'd1;
    s    = (m ? (aa - bb) : (aa + bb)) & mask;
    co   = m ? (aa >= bb) : ((((aa + bb) >> w) & 64'd1) != 0);
    sa   = aa[w-1] ? longint'(aa) - longint'(64'd1 << w) : longint'(aa);
    sb   = bb[w-1] ? longint'(bb) - longint'(64'd1 << w) : longint'(bb);
    t    = m ? sa - sb : sa + sb;
    lim  = longint'(64'd1 << (w - 1));
    ov   = (t >= lim) || (t < -lim);
    z    = (s == 0);
  endtask

  // Drives one 16-bit op and observes it for 8 edges after accept.
  task automatic do_op16(input logic m, input logic [15:0] aa, input logic [15:0] bb,
                         input bit hold, output logic [15:0] s, output logic co,
                         output logic ov, output logic z, output int dcnt,
                         output int dedge, output bit partial);
    logic [15:0] prev;
    prev    = sum16;
    dcnt    = 0;
    dedge   = -1;
    partial = 1'b0;
    s = '0; co = 1'b0; ov = 1'b0; z = 1'b0;
    mode16 = m; a16 = aa; b16 = bb; start16 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start16 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (hold) begin
        a16 = 16'($urandom); b16 = 16'($urandom); mode16 = ~mode16;
      end
      @(posedge clk); #1;
      if (done16) begin
        dcnt++;
        if (dedge < 0) begin
          dedge = e; s = sum16; co = cout16; ov = ovfl16; z = zero16;
        end
      end else if (dcnt == 0 && sum16 !== prev) begin
        partial = 1'b1;
      end
      if (hold && e == 3) start16 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start16 = 0; mode16 = 0; a16 = '0; b16 = '0;
    start32 = 0; mode32 = 0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({busy16, done16, sum16, cout16, ovfl16, zero16} !== 21'd0) begin
      errors++;
      $display("FAIL reset16: got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
               busy16, done16, sum16, cout16, ovfl16, zero16);
    end
    checks++;
    if ({busy32, done32, sum32, cout32, ovfl32, zero32} !== 37'd0) begin
      errors++;
      $display("FAIL reset32: got busy=%b done=%b sum=%h want all 0", busy32, done32, sum32);
    end
  endtask

  task automatic test_add_carry();
    logic [15:0] s; logic co, ov, z; int dc, de; bit part;
    do_op16(1'b0, 16'h00FF, 16'h0001, 1'b0, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'h0100 || co !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL add_carry: got sum=%h c=%b v=%b z=%b want 0100 0 0 0", s, co, ov, z);
    end
    checks++;
    if (dc !== 1 || de !== 2) begin
      errors++;
      $display("FAIL add_carry_timing: got done count=%0d edge=%0d want 1 at edge 2", dc, de);
    end
    checks++;
    if (part) begin
      errors++;
      $display("FAIL add_carry_partial: got sum changed before done want held");
    end
  endtask

  task automatic test_add_ovfl();
    logic [15:0] s; logic co, ov, z; int dc, de; bit part;
    do_op16(1'b0, 16'h7FFF, 16'h0001, 1'b0, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1 || z !== 1'b0 || dc !== 1) begin
      errors++;
      $display("FAIL add_ovfl: got sum=%h c=%b v=%b z=%b n=%0d want 8000 0 1 0 1",
               s, co, ov, z, dc);
    end
  endtask

  task automatic test_sub_basic();
    logic [15:0] s; logic co, ov, z; int dc, de; bit part;
    do_op16(1'b1, 16'h0000, 16'h0001, 1'b0, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'hFFFF || co !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("FAIL sub_0_1: got sum=%h c=%b v=%b z=%b want ffff 0 0 0", s, co, ov, z);
    end
    do_op16(1'b1, 16'h8000, 16'h0001, 1'b0, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL sub_min_1: got sum=%h c=%b v=%b z=%b want 7fff 1 1 0", s, co, ov, z);
    end
    do_op16(1'b1, 16'h0005, 16'h8000, 1'b0, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'h8005 || co !== 1'b0 || ov !== 1'b1) begin
      errors++;
      $display("FAIL sub_minus_min: got sum=%h c=%b v=%b want 8005 0 1", s, co, ov);
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] s; logic co, ov, z; int dc, de; bit part;
    do_op16(1'b1, 16'h1234, 16'h1234, 1'b1, s, co, ov, z, dc, de, part);
    checks++;
    if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0 || z !== 1'b1) begin
      errors++;
      $display("FAIL sub_equal: got sum=%h c=%b v=%b z=%b want 0000 1 0 1", s, co, ov, z);
    end
    checks++;
    if (dc !== 1 || de !== 2) begin
      errors++;
      $display("FAIL start_ignored: got done count=%0d edge=%0d want 1 at edge 2", dc, de);
    end
  endtask

  task automatic test_rst_abort();
    int dc;
    logic [15:0] s; logic co, ov, z; int dn, de; bit part;
    // Leave non-zero result and flags so the abort has something to clear.
    do_op16(1'b1, 16'h8000, 16'h0001, 1'b0, s, co, ov, z, dn, de, part);
    mode16 = 1'b0; a16 = 16'h00FF; b16 = 16'h0001; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy16, done16, sum16, cout16, ovfl16, zero16} !== 21'd0) begin
      errors++;
      $display("FAIL rst_abort: got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
               busy16, done16, sum16, cout16, ovfl16, zero16);
    end
    dc = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (done16) dc++;
    end
    checks++;
    if (dc !== 0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done pulses=%0d busy=%b want 0 0", dc, busy16);
    end
  endtask

  task automatic test_random16();
    logic [15:0] s, ra, rb; logic co, ov, z, rm; int dc, de; bit part;
    longint unsigned es; bit eco, eov, ez;
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom_range(0, 1));
      model(16, rm, 64'(ra), 64'(rb), es, eco, eov, ez);
      do_op16(rm, ra, rb, 1'b0, s, co, ov, z, dc, de, part);
      checks++;
      if (s !== 16'(es) || co !== eco || ov !== eov || z !== ez || dc !== 1 || de !== 2) begin
        errors++;
        $display("FAIL rand16 %h %s %h: got %h c=%b v=%b z=%b n=%0d@%0d want %h c=%b v=%b z=%b",
                 ra, rm ? "-" : "+", rb, s, co, ov, z, dc, de, 16'(es), eco, eov, ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint unsigned es; bit eco, eov, ez;
    int edges;
    for (int n = 0; n < 1000; n++) begin
      a32 = $urandom; b32 = $urandom; mode32 = 1'($urandom_range(0, 1));
      if (n % 50 == 7) b32 = 32'h8000_0000;
      if (n % 50 == 11) b32 = a32;
      model(32, mode32, 64'(a32), 64'(b32), es, eco, eov, ez);
      start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      edges = 0;
      while (!done32 && edges < 12) begin
        @(posedge clk); #1;
        edges++;
      end
      checks++;
      if (!done32 || edges !== 4) begin
        errors++;
        $display("FAIL b2b_latency op %0d: got done=%b after %0d edges want 1 after 4",
                 n, done32, edges);
      end
      checks++;
      if (sum32 !== 32'(es) || cout32 !== eco || ovfl32 !== eov || zero32 !== ez) begin
        errors++;
        $display("FAIL b2b_result op %0d %h %s %h: got %h c=%b v=%b z=%b want %h c=%b v=%b z=%b",
                 n, a32, mode32 ? "-" : "+", b32, sum32, cout32, ovfl32, zero32,
                 32'(es), eco, eov, ez);
      end
      @(posedge clk); #1;
      checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle op %0d: got busy=%b done=%b want 0 0", n, busy32, done32);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add_carry();
    test_add_ovfl();
    test_sub_basic();
    test_start_ignored();
    test_rst_abort();
    test_random16();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
